// File: rtl/rst_pkg.sv
// Shared types and limits for the reset synchroniser / release sequencer.
`timescale 1ns/1ps
package rst_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STRETCH = 2'd1,
    SEQ     = 2'd2,
    DONE    = 2'd3
  } rst_state_e;

  localparam int MIN_SYNC_STAGES = 2;
  localparam int MIN_N_OUT       = 1;
  localparam int MIN_MIN_ASSERT  = 1;
  localparam int MIN_RELEASE_GAP = 1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_sync_chain.sv
// Reset-deassertion synchroniser: assertion is asynchronous, release is aligned to clk_sync.
`timescale 1ns/1ps
module rst_sync_chain
  import rst_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_sync,
  input  logic async_rst,
  output logic sync_ok
);

  if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync_stages
    $error("rst_sync_chain: SYNC_STAGES must be at least %0d", MIN_SYNC_STAGES);
  end

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk_sync or negedge async_rst) begin
    if (!async_rst) chain <= '0;
    else            chain <= {chain[SYNC_STAGES-2:0], 1'b1};
  end

  assign sync_ok = chain[SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset synchroniser plus ordered release of N_OUT active-low resets with programmable spacing.
//   state   | meaning
//   HOLD    | reset condition present (or just cleared); all outputs held in reset
//   STRETCH | minimum assertion time running before sync_rst[0] releases
//   SEQ     | releasing the remaining outputs one every RELEASE_GAP cycles
//   DONE    | all outputs released, waiting for the next reset condition
`timescale 1ns/1ps
module rst_seq_ctrl
  import rst_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int N_OUT       = 3,
  parameter int MIN_ASSERT  = 4,
  parameter int RELEASE_GAP = 8,
  parameter int CNT_W       = $clog2(max_int(MIN_ASSERT, RELEASE_GAP) + 1)
) (
  input  logic             clk_sync,
  input  logic             async_rst,
  input  logic             sw_rst_req,
  output logic [N_OUT-1:0] sync_rst,
  output logic             rst_done,
  output logic             busy
);

  localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  if (N_OUT < MIN_N_OUT) begin : g_bad_n_out
    $error("rst_seq_ctrl: N_OUT must be at least %0d", MIN_N_OUT);
  end
  if (MIN_ASSERT < MIN_MIN_ASSERT) begin : g_bad_min_assert
    $error("rst_seq_ctrl: MIN_ASSERT must be at least %0d", MIN_MIN_ASSERT);
  end
  if (RELEASE_GAP < MIN_RELEASE_GAP) begin : g_bad_release_gap
    $error("rst_seq_ctrl: RELEASE_GAP must be at least %0d", MIN_RELEASE_GAP);
  end

  logic sync_ok;
  logic rst_cond;

  rst_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N_OUT-1:0] rel_q, rel_d;
  logic             done_q, done_d;

  rst_sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_chain (
    .clk_sync (clk_sync),
    .async_rst(async_rst),
    .sync_ok  (sync_ok)
  );

  assign rst_cond = !sync_ok || sw_rst_req;

  always_ff @(posedge clk_sync or negedge async_rst) begin
    if (!async_rst) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      rel_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rel_q   <= rel_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rel_d   = rel_q;
    done_d  = done_q;

    if (rst_cond) begin
      state_d = HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      rel_d   = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        HOLD: begin
          state_d = STRETCH;
          cnt_d   = CNT_W'(MIN_ASSERT - 1);
        end
        STRETCH: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            rel_d = N_OUT'(1);
            idx_d = IDX_W'(1);
            cnt_d = CNT_W'(RELEASE_GAP - 1);
            if (N_OUT == 1) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = SEQ;
            end
          end
        end
        SEQ: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            // Released bits form a thermometer code, so setting bit idx is a shift-in of 1.
            rel_d = (rel_q << 1) | N_OUT'(1);
            if (idx_q == IDX_W'(N_OUT - 1)) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
              cnt_d = CNT_W'(RELEASE_GAP - 1);
            end
          end
        end
        DONE:    state_d = DONE;
        default: state_d = HOLD;
      endcase
    end
  end

  assign sync_rst = rel_q;
  assign rst_done = done_q;
  assign busy     = (state_q != DONE);

endmodule
